hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the five-stage RISC-V core. It drives the enable and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the EX-stage operand forwarding selects. It also sequences multi-cycle data-memory accesses with a wait/timeout state machine. It sits beside the datapath, observes register addresses and control bits from each stage, and contains no datapath storage of its own.

## Interface
- `ADDR_W`, 5: register address width.
- `MEM_TIMEOUT`, 255: maximum consecutive data-memory wait cycles before a fault; range 1..65535.
- `i_clk  in  1`: clock, rising edge.
- `i_rst  in  1`: reset, asynchronous, active-high.
- `i_rs1_ID, i_rs2_ID  in  ADDR_W`: source register addresses of the instruction in ID.
- `i_rs1_EX, i_rs2_EX, i_rd_EX  in  ADDR_W`: source and destination register addresses in EX.
- `i_rd_MEM, i_rd_WB  in  ADDR_W`: destination register addresses in MEM and WB.
- `i_reg_write_EX, i_reg_write_MEM, i_reg_write_WB  in  1`: register-write enables per stage.
- `i_result_src_EX  in  2`: result source in EX; `2'b01` means load.
- `i_pc_src_EX  in  1`: branch or jump taken, resolved in EX.
- `i_mem_req_MEM  in  1`: load or store present in MEM.
- `i_mem_ready  in  1`: data memory completes the access this cycle.
- `o_fwd_a_EX, o_fwd_b_EX  out  2`: operand select; `00` register file, `01` WB result, `10` MEM ALU result.
- `o_stall_IF, o_stall_ID, o_stall_EX, o_stall_MEM  out  1`: hold the PC or the named stage register (register enable = ~stall).
- `o_flush_ID, o_flush_EX, o_flush_WB  out  1`: load a bubble into the named stage register at the next edge.
- `o_mem_timeout  out  1`: sticky fault flag.
- `o_stall_cycles  out  16`: saturating count of cycles with `o_stall_IF` high.

## Operation
- **Forwarding (per operand, independently):**
  - Select MEM when `i_reg_write_MEM`, `i_rd_MEM != 0` and `i_rd_MEM == rsX_EX`.
  - Otherwise select WB under the same conditions using the WB-stage signals.
  - Otherwise select the register file. MEM has priority over WB.
- **Load-use hazard:** asserted when `i_result_src_EX == 2'b01`, `i_rd_EX != 0`, and `i_rd_EX` matches `i_rs1_ID` or `i_rs2_ID`.
  - Response: stall IF and ID; flush EX.
- **Branch taken (`i_pc_src_EX`):** flush ID and EX; no stall.
  - If a load-use hazard occurs in the same cycle, the branch wins. The ID instruction is wrong-path.
- **Memory wait:** `mem_stall = i_mem_req_MEM & ~i_mem_ready`.
  - Response: stall IF, ID, EX and MEM; flush WB.
  - Memory wait has top priority: load-use and branch flushes are suppressed while it is active. EX is held, so the branch re-asserts after the wait ends.
- **FSM states:** `RUN`, `MEM_WAIT`, `FAULT`.
  - `RUN` → `MEM_WAIT` on `mem_stall`.
  - `MEM_WAIT` → `RUN` when `mem_stall` is low.
  - `MEM_WAIT` → `FAULT` when `mem_stall` is high and `wait_cnt == MEM_TIMEOUT-1`.
  - `FAULT` is terminal until reset. In `FAULT` all four stalls are high, all flushes are low, and `o_mem_timeout` is 1.
- **`wait_cnt` (16 bits):** increments at each edge with `mem_stall` high; clears at each edge with `mem_stall` low.
- **`o_stall_cycles`:** increments at each edge with `o_stall_IF` high; holds at `16'hFFFF`.
- **Register x0:** never matches for forwarding or hazard detection.

## Timing
- Forwarding, stall and flush outputs are combinational from the inputs and the current state. Zero-cycle latency: a hazard present in cycle N is acted on at the edge ending cycle N.
- `i_mem_ready` high in the first request cycle produces no stall and no state change.
- `o_mem_timeout` rises on the edge that enters `FAULT`: exactly `MEM_TIMEOUT` stalled cycles after the first one.
- **Reset values:**
  - State `RUN`, `wait_cnt` 0, `o_stall_cycles` 0, `o_mem_timeout` 0.
  - Combinational outputs follow the inputs; all are 0 when the inputs are 0.
- **Reset asserted mid-wait or in `FAULT`:** returns to `RUN` immediately and asynchronously; counters clear.

## Configuration
- `HAZARD_FWD_EN` defined: forwarding as above.
- `HAZARD_FWD_EN` undefined:
  - `o_fwd_a_EX` and `o_fwd_b_EX` are tied to `00`.
  - RAW stall: stall IF and ID and flush EX when `rs1_ID` or `rs2_ID` (nonzero) matches `i_rd_EX` with `i_reg_write_EX`, or matches `i_rd_MEM` with `i_reg_write_MEM`.
  - WB needs no stall because the register file is write-through.
  - Priority relative to the branch and memory-wait rules is unchanged.

## Structure
- Shared package `pipeline_pkg`:
  - `fwd_sel_e` (`FWD_RF=2'b00`, `FWD_WB=2'b01`, `FWD_MEM=2'b10`).
  - `RESULT_SRC_LOAD = 2'b01`.
  - `hz_state_e` (`RUN`, `MEM_WAIT`, `FAULT`).
- Sub-module `hazard_fwd_sel`: combinational single-operand forwarding select, instantiated twice (operands A and B).

## Test plan
- **Forwarding priority:** `i_rs1_EX=5`, `i_rd_MEM=5`, `i_rd_WB=5`, both write enables high → `o_fwd_a_EX=10`. Clearing `i_reg_write_MEM` → `01`. Setting `i_rd_MEM=i_rd_WB=0` with `i_rs1_EX=0` → `00`.
- **Load-use:** `i_result_src_EX=01`, `i_rd_EX=7`, `i_rs2_ID=7` → `o_stall_IF=o_stall_ID=o_flush_EX=1` for one cycle; `o_stall_cycles` increments by 1.
- **Branch vs load-use same cycle:** load-use inputs above plus `i_pc_src_EX=1` → `o_flush_ID=o_flush_EX=1`, `o_stall_IF=0`.
- **Memory wait:** `i_mem_req_MEM=1`, `i_mem_ready=0` for 3 cycles, then 1 → all stalls and `o_flush_WB` high for 3 cycles, released in the 4th; state returns to `RUN`; the branch input asserted during the wait produces no flush.
- **Timeout:** `MEM_TIMEOUT=4`, ready never asserted → `o_mem_timeout` rises after the 4th stalled edge and stays high; stalls remain high. Pulsing `i_rst` mid-cycle clears everything asynchronously.
- **Without `HAZARD_FWD_EN`:** `i_rd_MEM=3`, `i_reg_write_MEM=1`, `i_rs1_ID=3` → `o_stall_ID=1`, `o_flush_EX=1`, both forwarding selects `00`.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: forwarding select codes, result-source
// encodings and the hazard controller's state type.
package pipeline_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    FAULT
  } hz_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Single-operand EX forwarding select. MEM beats WB; x0 never forwards.
module hazard_fwd_sel
  import pipeline_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] i_rs_EX,
  input  logic [ADDR_W-1:0] i_rd_MEM,
  input  logic [ADDR_W-1:0] i_rd_WB,
  input  logic              i_reg_write_MEM,
  input  logic              i_reg_write_WB,
  output logic [1:0]        o_sel
);

  // Priority select: youngest producer (MEM) wins over WB.
  always_comb begin
    // NOTE: a default assigned first keeps every path driven, so no latch is inferred.
    o_sel = FWD_RF;
    if (i_reg_write_MEM && (i_rd_MEM != '0) && (i_rd_MEM == i_rs_EX)) begin
      o_sel = FWD_MEM;
    end else if (i_reg_write_WB && (i_rd_WB != '0) && (i_rd_WB == i_rs_EX)) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: forwarding selects, stall/flush
// controls, and the data-memory wait/timeout state machine.
// Build option HAZARD_FWD_EN: when defined, EX operands are forwarded and only
// load-use hazards stall; when undefined, forwarding is off and any RAW
// dependency on EX or MEM stalls instead.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_rs1_ID,
  input  logic [ADDR_W-1:0] i_rs2_ID,
  input  logic [ADDR_W-1:0] i_rs1_EX,
  input  logic [ADDR_W-1:0] i_rs2_EX,
  input  logic [ADDR_W-1:0] i_rd_EX,
  input  logic [ADDR_W-1:0] i_rd_MEM,
  input  logic [ADDR_W-1:0] i_rd_WB,
  input  logic              i_reg_write_EX,
  input  logic              i_reg_write_MEM,
  input  logic              i_reg_write_WB,
  input  logic [1:0]        i_result_src_EX,
  input  logic              i_pc_src_EX,
  input  logic              i_mem_req_MEM,
  input  logic              i_mem_ready,
  output logic [1:0]        o_fwd_a_EX,
  output logic [1:0]        o_fwd_b_EX,
  output logic              o_stall_IF,
  output logic              o_stall_ID,
  output logic              o_stall_EX,
  output logic              o_stall_MEM,
  output logic              o_flush_ID,
  output logic              o_flush_EX,
  output logic              o_flush_WB,
  output logic              o_mem_timeout,
  output logic [15:0]       o_stall_cycles
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

  hz_state_e   state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic        mem_stall;
  logic        data_hazard;

  assign mem_stall = i_mem_req_MEM & ~i_mem_ready;

`ifdef HAZARD_FWD_EN
  hazard_fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_a (
    .i_rs_EX         (i_rs1_EX),
    .i_rd_MEM        (i_rd_MEM),
    .i_rd_WB         (i_rd_WB),
    .i_reg_write_MEM (i_reg_write_MEM),
    .i_reg_write_WB  (i_reg_write_WB),
    .o_sel           (o_fwd_a_EX)
  );

  hazard_fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_b (
    .i_rs_EX         (i_rs2_EX),
    .i_rd_MEM        (i_rd_MEM),
    .i_rd_WB         (i_rd_WB),
    .i_reg_write_MEM (i_reg_write_MEM),
    .i_reg_write_WB  (i_reg_write_WB),
    .o_sel           (o_fwd_b_EX)
  );

  // With forwarding, only a load in EX feeding the ID instruction must wait.
  assign data_hazard = (i_result_src_EX == RESULT_SRC_LOAD) && (i_rd_EX != '0) &&
                       ((i_rd_EX == i_rs1_ID) || (i_rd_EX == i_rs2_ID));

  // EX write enable only matters for the non-forwarding hazard check.
  logic unused_ok;
  assign unused_ok = i_reg_write_EX;
`else
  logic rs1_raw, rs2_raw;

  assign o_fwd_a_EX = FWD_RF;
  assign o_fwd_b_EX = FWD_RF;

  // Register file is write-through, so only EX and MEM producers block ID.
  assign rs1_raw = (i_rs1_ID != '0) &&
                   ((i_reg_write_EX && (i_rd_EX == i_rs1_ID)) ||
                    (i_reg_write_MEM && (i_rd_MEM == i_rs1_ID)));
  assign rs2_raw = (i_rs2_ID != '0) &&
                   ((i_reg_write_EX && (i_rd_EX == i_rs2_ID)) ||
                    (i_reg_write_MEM && (i_rd_MEM == i_rs2_ID)));
  assign data_hazard = rs1_raw | rs2_raw;

  // EX sources, WB producer and result source only feed the forwarding path.
  logic unused_ok;
  assign unused_ok = ^{i_rs1_EX, i_rs2_EX, i_rd_WB, i_reg_write_WB, i_result_src_EX};
`endif

  // Next state plus stall/flush outputs; memory wait beats branch beats data hazard.
  always_comb begin
    state_d     = state_q;
    o_stall_IF  = 1'b0;
    o_stall_ID  = 1'b0;
    o_stall_EX  = 1'b0;
    o_stall_MEM = 1'b0;
    o_flush_ID  = 1'b0;
    o_flush_EX  = 1'b0;
    o_flush_WB  = 1'b0;

    case (state_q)
      // A one-cycle budget faults on the very first stalled edge.
      RUN:      if (mem_stall) state_d = (MEM_TIMEOUT == 1) ? FAULT : MEM_WAIT;
      MEM_WAIT: if (!mem_stall) state_d = RUN;
                else if (wait_cnt_q >= TIMEOUT_LAST) state_d = FAULT;
      FAULT:    state_d = FAULT;
      default:  state_d = RUN;
    endcase

    if (state_q == FAULT) begin
      o_stall_IF  = 1'b1;
      o_stall_ID  = 1'b1;
      o_stall_EX  = 1'b1;
      o_stall_MEM = 1'b1;
    end else if (mem_stall) begin
      o_stall_IF  = 1'b1;
      o_stall_ID  = 1'b1;
      o_stall_EX  = 1'b1;
      o_stall_MEM = 1'b1;
      o_flush_WB  = 1'b1;
    end else if (i_pc_src_EX) begin
      // The ID instruction is wrong-path, so a coincident load-use is moot.
      o_flush_ID = 1'b1;
      o_flush_EX = 1'b1;
    end else if (data_hazard) begin
      o_stall_IF = 1'b1;
      o_stall_ID = 1'b1;
      o_flush_EX = 1'b1;
    end
  end

  // Saturating counters: consecutive memory-wait cycles and total front-end stalls.
  always_comb begin
    wait_cnt_d     = '0;
    stall_cycles_d = stall_cycles_q;
    if (mem_stall) begin
      wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
    end
    if (o_stall_IF && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  // State and counter registers; reset returns to RUN immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (i_rst) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign o_mem_timeout  = (state_q == FAULT);
  assign o_stall_cycles = stall_cycles_q;

endmodule
